// File: rtl/conv2d_engine_cfg.sv
// 3x3 streaming valid-mode convolution with loadable signed kernel, optional ReLU and frame-end flags.
// Latency: 4 cycles from window-completing pixel to result; no backpressure, pixel_valid gaps only stall the window.
module conv2d_engine_cfg #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int PIXEL_W    = 8,
  parameter int WEIGHT_W   = 8,
  localparam int OUT_W     = PIXEL_W + WEIGHT_W + 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_signal,
  input  logic                       relu_en,
  input  logic                       weight_wr_en,
  input  logic [3:0]                 weight_addr,
  input  logic signed [WEIGHT_W-1:0] weight_data,
  input  logic [PIXEL_W-1:0]         pixel_in,
  input  logic                       pixel_valid,
  output logic signed [OUT_W-1:0]    result_out,
  output logic                       result_valid,
  output logic                       result_last,
  output logic                       busy,
  output logic                       done_signal
);

  localparam int PROD_W = PIXEL_W + WEIGHT_W + 1;
  localparam int XW     = $clog2(IMG_WIDTH);
  localparam int YW     = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state;
  logic [XW-1:0]               cnt_x;
  logic [YW-1:0]               cnt_y;
  logic [1:0]                  drain_cnt;
  logic                        relu_q;
  logic signed [WEIGHT_W-1:0]  kern [9];
  logic [PIXEL_W-1:0]          lb1 [IMG_WIDTH];
  logic [PIXEL_W-1:0]          lb2 [IMG_WIDTH];
  logic [PIXEL_W-1:0]          win [3][3];
  logic signed [PROD_W-1:0]    prod [3][3];
  logic signed [OUT_W-1:0]     row_sum [3];
  logic signed [OUT_W-1:0]     total;
  logic                        v0, v1, v2, v3;
  logic                        l0, l1, l2, l3;

  logic accept, x_last, y_last, win_done;

  assign accept   = (state == RUN) && pixel_valid;
  assign x_last   = (cnt_x == XW'(IMG_WIDTH - 1));
  assign y_last   = (cnt_y == YW'(IMG_HEIGHT - 1));
  assign win_done = accept && (cnt_x >= XW'(2)) && (cnt_y >= YW'(2));

  function automatic logic signed [PROD_W-1:0] mul(input logic [PIXEL_W-1:0] p,
                                                   input logic signed [WEIGHT_W-1:0] w);
    logic signed [PROD_W-1:0] pe, we;
    pe = $signed({{(PROD_W - PIXEL_W){1'b0}}, p});
    we = {{(PROD_W - WEIGHT_W){w[WEIGHT_W-1]}}, w};
    return pe * we;
  endfunction

  function automatic logic signed [OUT_W-1:0] sx(input logic signed [PROD_W-1:0] v);
    return {{(OUT_W - PROD_W){v[PROD_W-1]}}, v};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt_x       <= '0;
      cnt_y       <= '0;
      drain_cnt   <= '0;
      relu_q      <= 1'b0;
      busy        <= 1'b0;
      done_signal <= 1'b0;
    end else begin
      done_signal <= 1'b0;
      case (state)
        IDLE: if (start_signal) begin
          state  <= RUN;
          relu_q <= relu_en;
          cnt_x  <= '0;
          cnt_y  <= '0;
          busy   <= 1'b1;
        end
        RUN: if (pixel_valid) begin
          if (x_last) begin
            cnt_x <= '0;
            if (y_last) begin
              state     <= DRAIN;
              drain_cnt <= 2'd3;
            end else begin
              cnt_y <= cnt_y + 1'b1;
            end
          end else begin
            cnt_x <= cnt_x + 1'b1;
          end
        end
        DRAIN: if (drain_cnt == 2'd0) state <= DONE;
               else drain_cnt <= drain_cnt - 1'b1;
        DONE: begin
          state       <= IDLE;
          busy        <= 1'b0;
          done_signal <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Kernel resets to Sobel-X; index is row*3+col with row 0 the oldest line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kern[0] <= WEIGHT_W'(1);  kern[1] <= '0; kern[2] <= WEIGHT_W'(-1);
      kern[3] <= WEIGHT_W'(2);  kern[4] <= '0; kern[5] <= WEIGHT_W'(-2);
      kern[6] <= WEIGHT_W'(1);  kern[7] <= '0; kern[8] <= WEIGHT_W'(-1);
    end else if (state == IDLE && weight_wr_en && weight_addr < 4'd9) begin
      kern[weight_addr] <= weight_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[cnt_x] <= lb1[cnt_x];
      lb1[cnt_x] <= pixel_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c]  <= '0;
          prod[r][c] <= '0;
        end
        row_sum[r] <= '0;
      end
      total        <= '0;
      result_out   <= '0;
      {v0, v1, v2, v3, l0, l1, l2, l3} <= '0;
      result_valid <= 1'b0;
      result_last  <= 1'b0;
    end else begin
      if (accept) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            win[r][c] <= win[r][c+1];
        win[0][2] <= lb2[cnt_x];
        win[1][2] <= lb1[cnt_x];
        win[2][2] <= pixel_in;
      end
      v0 <= win_done;
      l0 <= win_done && x_last && y_last;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++)
          prod[r][c] <= mul(win[r][c], kern[r*3 + c]);
        row_sum[r] <= sx(prod[r][0]) + sx(prod[r][1]) + sx(prod[r][2]);
      end
      total        <= row_sum[0] + row_sum[1] + row_sum[2];
      result_out   <= (relu_q && total[OUT_W-1]) ? '0 : total;
      v1 <= v0;  v2 <= v1;  v3 <= v2;  result_valid <= v3;
      l1 <= l0;  l2 <= l1;  l3 <= l2;  result_last  <= l3;
    end
  end

endmodule

// File: tb/tb_conv2d_engine_cfg.sv
// Directed bench for conv2d_engine_cfg: 32x32 default instance plus a 5x4 instance.
module tb_conv2d_engine_cfg;
  localparam int OUT_W = 21;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic                    start_signal, relu_en, weight_wr_en, pixel_valid;
  logic [3:0]              weight_addr;
  logic signed [7:0]       weight_data;
  logic [7:0]              pixel_in;
  logic signed [OUT_W-1:0] result_out;
  logic                    result_valid, result_last, busy, done_signal;

  logic                    s_start, s_wr, s_vld;
  logic [3:0]              s_addr;
  logic signed [7:0]       s_data;
  logic [7:0]              s_pix;
  logic signed [OUT_W-1:0] s_res;
  logic                    s_rv, s_rl, s_busy, s_done;

  conv2d_engine_cfg dut (
    .clk(clk), .rst(rst), .start_signal(start_signal), .relu_en(relu_en),
    .weight_wr_en(weight_wr_en), .weight_addr(weight_addr), .weight_data(weight_data),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .result_out(result_out),
    .result_valid(result_valid), .result_last(result_last), .busy(busy),
    .done_signal(done_signal)
  );

  conv2d_engine_cfg #(.IMG_WIDTH(5), .IMG_HEIGHT(4)) dut_s (
    .clk(clk), .rst(rst), .start_signal(s_start), .relu_en(1'b0),
    .weight_wr_en(s_wr), .weight_addr(s_addr), .weight_data(s_data),
    .pixel_in(s_pix), .pixel_valid(s_vld), .result_out(s_res),
    .result_valid(s_rv), .result_last(s_rl), .busy(s_busy),
    .done_signal(s_done)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main-instance monitor: edge index of each completing pixel is queued by the driver.
  int comp_q[$];
  int exp_val, exp_n, n_res, n_done, last_cyc, e;
  bit mon_en;

  always @(negedge clk) begin
    if (result_valid) begin
      n_res++;
      if (mon_en) begin
        if (comp_q.size() == 0) chk("res_extra", 1, 0);
        else begin
          e = comp_q.pop_front();
          chk("res_val", int'(result_out), exp_val);
          chk("res_lat", cyc - e, 4);
        end
        chk("res_last", int'(result_last), int'(n_res == exp_n));
      end
      if (result_last) last_cyc = cyc;
    end
    if (done_signal) begin
      n_done++;
      if (mon_en) chk("done_time", cyc - last_cyc, 1);
    end
  end

  // 5x4 instance, pixels 5y+x+1, all-ones kernel: each result is 9x the window centre.
  int s_exp [6] = '{63, 72, 81, 108, 117, 126};
  int s_idx = 0;

  always @(negedge clk) begin
    if (s_rv) begin
      if (s_idx < 6) begin
        chk("s_val", int'(s_res), s_exp[s_idx]);
        chk("s_last", int'(s_rl), int'(s_idx == 5));
      end else begin
        chk("s_extra", 1, 0);
      end
      s_idx++;
    end
  end

  task automatic wr(input int a, input int d);
    weight_wr_en = 1'b1;
    weight_addr  = 4'(a);
    weight_data  = 8'(d);
    @(posedge clk); #1;
    weight_wr_en = 1'b0;
  endtask

  // mode 0: ramp pixel=x, mode 1: constant 255
  task automatic run_frame(input int mode, input bit gaps, input bit relu, input int expv,
                           input bit w8, input int ign_row, input int abort_row);
    bit got;
    exp_val = expv;
    exp_n   = 900;
    n_res   = 0;
    comp_q.delete();
    start_signal = 1'b1;
    relu_en      = relu;
    if (w8) begin
      weight_wr_en = 1'b1; weight_addr = 4'd8; weight_data = 8'sd1;
    end
    @(posedge clk); #1;
    start_signal = 1'b0; relu_en = 1'b0; weight_wr_en = 1'b0;
    chk("busy_rise", int'(busy), 1);
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        if (y == abort_row && x == 0) begin
          pixel_valid = 1'b0;
          mon_en = 1'b0;
          rst = 1'b0;
          #1;
          chk("abort_res", int'(result_out), 0);
          chk("abort_vld", int'(result_valid), 0);
          chk("abort_last", int'(result_last), 0);
          chk("abort_busy", int'(busy), 0);
          chk("abort_done", int'(done_signal), 0);
          @(posedge clk); #1;
          rst = 1'b1;
          comp_q.delete();
          return;
        end
        if (gaps) begin
          while ($urandom_range(1, 0) == 0) begin
            pixel_valid = 1'b0;
            @(posedge clk); #1;
          end
        end
        pixel_in    = (mode == 0) ? 8'(x) : 8'd255;
        pixel_valid = 1'b1;
        if (y == ign_row && x == 0) begin
          weight_wr_en = 1'b1; weight_addr = 4'd4; weight_data = 8'sd50;
          start_signal = 1'b1;
        end
        @(posedge clk); #1;
        weight_wr_en = 1'b0; start_signal = 1'b0;
        if (x >= 2 && y >= 2) comp_q.push_back(cyc);
      end
    end
    pixel_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done_signal) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(got), 1);
    chk("busy_fall", int'(busy), 0);
    chk("res_cnt", n_res, exp_n);
    chk("q_empty", comp_q.size(), 0);
  endtask

  initial begin
    int d0;
    bit s_got;
    rst = 1'b0;
    start_signal = 1'b0; relu_en = 1'b0; weight_wr_en = 1'b0; weight_addr = '0;
    weight_data = '0; pixel_in = '0; pixel_valid = 1'b0;
    s_start = 1'b0; s_wr = 1'b0; s_vld = 1'b0; s_addr = '0; s_data = '0; s_pix = '0;
    mon_en = 1'b1; n_done = 0; last_cyc = -100; exp_val = 0; exp_n = 900; n_res = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", int'(result_out), 0);
    chk("rst_vld", int'(result_valid), 0);
    chk("rst_last", int'(result_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done_signal), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_frame(0, 1'b0, 1'b0, -8, 1'b0, -1, -1);
    run_frame(0, 1'b0, 1'b1, 0, 1'b0, -1, -1);

    for (int a = 0; a < 9; a++) wr(a, -128);
    run_frame(1, 1'b0, 1'b0, -293760, 1'b0, -1, -1);

    // addr 8 is left at -128 and only loaded together with start; addr 12 must be dropped
    for (int a = 0; a < 8; a++) wr(a, 1);
    wr(12, -128);
    run_frame(1, 1'b0, 1'b0, 2295, 1'b1, -1, -1);

    run_frame(1, 1'b0, 1'b0, 2295, 1'b0, 10, 20);
    d0 = n_done;
    n_res = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_no_done", n_done - d0, 0);
    chk("abort_no_res", n_res, 0);
    mon_en = 1'b1;

    // Ramp after reset: -8 only if the kernel went back to Sobel-X
    run_frame(0, 1'b1, 1'b0, -8, 1'b0, -1, -1);

    for (int a = 0; a < 9; a++) begin
      s_wr = 1'b1; s_addr = 4'(a); s_data = 8'sd1;
      @(posedge clk); #1;
    end
    s_wr = 1'b0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 5; x++) begin
        s_pix = 8'(5*y + x + 1);
        s_vld = 1'b1;
        @(posedge clk); #1;
      end
    end
    s_vld = 1'b0;
    s_got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (s_done) begin
        s_got = 1'b1;
        break;
      end
    end
    chk("s_done", int'(s_got), 1);
    chk("s_cnt", s_idx, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
